// File: rtl/fft_butterfly_add_stage_multi.sv
// LANES parallel complex float butterflies (a+b, a-b) with optional -j rotation of b, a fixed
// ADD_LAT pipeline and a credit-protected output FIFO. Macro FFT_BF_SCALE_EN enables halving.
`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module fft_butterfly_add_stage_multi #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned ADD_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_rot_mj,
    input  logic                           in_scale,
    input  logic [TAG_W-1:0]               in_tag,
    input  logic [LANES*`OVERALL_BITS-1:0] in_a_re,
    input  logic [LANES*`OVERALL_BITS-1:0] in_a_im,
    input  logic [LANES*`OVERALL_BITS-1:0] in_b_re,
    input  logic [LANES*`OVERALL_BITS-1:0] in_b_im,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [TAG_W-1:0]               out_tag,
    output logic [LANES*`OVERALL_BITS-1:0] out_apb_re,
    output logic [LANES*`OVERALL_BITS-1:0] out_apb_im,
    output logic [LANES*`OVERALL_BITS-1:0] out_amb_re,
    output logic [LANES*`OVERALL_BITS-1:0] out_amb_im
);
    localparam int unsigned FW = `OVERALL_BITS;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = FW - EW - 1;
    localparam int unsigned DW = LANES * FW;
    // Working significand: carry, hidden, fraction, guard, round, sticky.
    localparam int unsigned SW = MW + 5;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [FW-1:0] SIGN = {1'b1, {(FW-1){1'b0}}};
    localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    apb_re;
        logic [DW-1:0]    apb_im;
        logic [DW-1:0]    amb_re;
        logic [DW-1:0]    amb_im;
    } res_t;

    // Round-to-nearest-even float add with subnormals; any NaN or Inf-Inf gives a quiet NaN.
    function automatic logic [FW-1:0] fp_add(input logic [FW-1:0] x, input logic [FW-1:0] y);
        logic          sx, sy, sb, ss, st, up;
        int            ex, ey, eb, es, e, sh;
        logic [SW-1:0] mx, my, mb, ms, sum, mask;
        logic [MW+1:0] rm;
        logic [FW-1:0] res;
        sx = x[FW-1];
        sy = y[FW-1];
        ex = int'(x[FW-2:MW]);
        ey = int'(y[FW-2:MW]);
        res = '0;
        if (ex == EMAX || ey == EMAX) begin
            if ((ex == EMAX && x[MW-1:0] != '0) || (ey == EMAX && y[MW-1:0] != '0) ||
                (ex == EMAX && ey == EMAX && sx != sy)) begin
                res = QNAN;
            end else if (ex == EMAX) begin
                res = x;
            end else begin
                res = y;
            end
        end else begin
            mx = {1'b0, ex != 0, x[MW-1:0], 3'b000};
            my = {1'b0, ey != 0, y[MW-1:0], 3'b000};
            if (ex == 0) ex = 1;
            if (ey == 0) ey = 1;
            if (ex > ey || (ex == ey && mx >= my)) begin
                eb = ex; mb = mx; sb = sx; es = ey; ms = my; ss = sy;
            end else begin
                eb = ey; mb = my; sb = sy; es = ex; ms = mx; ss = sx;
            end
            sh = eb - es;
            if (sh >= int'(SW)) begin
                st = |ms;
                ms = '0;
            end else begin
                mask = ~({SW{1'b1}} << sh);
                st   = |(ms & mask);
                ms   = ms >> sh;
            end
            ms[0] = ms[0] | st;
            sum = (sb == ss) ? mb + ms : mb - ms;
            e = eb;
            if (sum == '0) begin
                res = {sb & ss, {(FW-1){1'b0}}};
            end else begin
                if (sum[SW-1]) begin
                    sum = {1'b0, sum[SW-1:2], sum[1] | sum[0]};
                    e = e + 1;
                end
                for (int i = 0; i < int'(SW); i++) begin
                    if (!sum[SW-2] && e > 1) begin
                        sum = sum << 1;
                        e = e - 1;
                    end
                end
                up = sum[2] & (sum[1] | sum[0] | sum[3]);
                rm = {1'b0, sum[SW-2:3]} + {{(MW+1){1'b0}}, up};
                if (rm[MW+1]) begin
                    rm = rm >> 1;
                    e = e + 1;
                end
                if (e >= EMAX) res = {sb, {EW{1'b1}}, {MW{1'b0}}};
                else res = {sb, EW'(rm[MW] ? e : 0), rm[MW-1:0]};
            end
        end
        return res;
    endfunction

`ifdef FFT_BF_SCALE_EN
    function automatic logic [FW-1:0] fp_half(input logic [FW-1:0] x);
        logic [EW-1:0] ef;
        ef = x[FW-2:MW];
        if (ef == '1) return x;
        if (ef <= EW'(1)) return {x[FW-1], {(FW-1){1'b0}}};
        return {x[FW-1], ef - EW'(1), x[MW-1:0]};
    endfunction
`else
    logic unused_scale;
    assign unused_scale = in_scale;
`endif

    res_t in_res, exit_res, rd_res;
    res_t pipe_q [ADD_LAT];
    res_t mem_q  [FIFO_DEPTH];
    logic [ADD_LAT-1:0] vld_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic accept, push, pop;
    int unsigned inflight;

    always_comb begin
        logic [FW-1:0] ar, ai, br, bi;
        in_res = '0;
        in_res.tag = in_tag;
        for (int k = 0; k < int'(LANES); k++) begin
            ar = in_a_re[k*FW +: FW];
            ai = in_a_im[k*FW +: FW];
            // -j*b: swap components and negate the new imaginary part.
            if (in_rot_mj) begin
                br = in_b_im[k*FW +: FW];
                bi = in_b_re[k*FW +: FW] ^ SIGN;
            end else begin
                br = in_b_re[k*FW +: FW];
                bi = in_b_im[k*FW +: FW];
            end
            in_res.apb_re[k*FW +: FW] = fp_add(ar, br);
            in_res.apb_im[k*FW +: FW] = fp_add(ai, bi);
            in_res.amb_re[k*FW +: FW] = fp_add(ar, br ^ SIGN);
            in_res.amb_im[k*FW +: FW] = fp_add(ai, bi ^ SIGN);
        end
    end

    assign accept = in_valid & in_ready;
    assign push   = vld_q[ADD_LAT-1];
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < int'(ADD_LAT); i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_q[0] <= in_res;
        for (int i = 1; i < int'(ADD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end

`ifdef FFT_BF_SCALE_EN
    logic [ADD_LAT-1:0] scl_q;
    always_ff @(posedge clk) begin
        scl_q[0] <= in_scale;
        for (int i = 1; i < int'(ADD_LAT); i++) scl_q[i] <= scl_q[i-1];
    end
`endif

    always_comb begin
        exit_res = pipe_q[ADD_LAT-1];
`ifdef FFT_BF_SCALE_EN
        if (scl_q[ADD_LAT-1]) begin
            for (int k = 0; k < int'(LANES); k++) begin
                exit_res.apb_re[k*FW +: FW] = fp_half(pipe_q[ADD_LAT-1].apb_re[k*FW +: FW]);
                exit_res.apb_im[k*FW +: FW] = fp_half(pipe_q[ADD_LAT-1].apb_im[k*FW +: FW]);
                exit_res.amb_re[k*FW +: FW] = fp_half(pipe_q[ADD_LAT-1].amb_re[k*FW +: FW]);
                exit_res.amb_im[k*FW +: FW] = fp_half(pipe_q[ADD_LAT-1].amb_im[k*FW +: FW]);
            end
        end
`endif
    end

    // Credits: anything in flight is guaranteed a FIFO slot on exit, so the pipe never stalls.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(ADD_LAT); i++) inflight = inflight + 32'(vld_q[i]);
        in_ready = (32'(cnt_q) + inflight) < FIFO_DEPTH;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= exit_res;
    end

    assign out_valid  = (cnt_q != '0);
    assign rd_res     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_tag    = rd_res.tag;
    assign out_apb_re = rd_res.apb_re;
    assign out_apb_im = rd_res.apb_im;
    assign out_amb_re = rd_res.amb_re;
    assign out_amb_im = rd_res.amb_im;

endmodule

// File: tb/tb_fft_butterfly_add_stage_multi.sv
// Scoreboard bench for fft_butterfly_add_stage_multi: binary32 reference built on real arithmetic.
`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module tb_fft_butterfly_add_stage_multi;
    localparam int unsigned LANES      = 2;
    localparam int unsigned TAG_W      = 8;
    localparam int unsigned ADD_LAT    = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DW         = LANES * 32;
    localparam logic [31:0] SGN        = 32'h8000_0000;

    logic clk, rst_n, in_valid, in_ready, in_rot_mj, in_scale, out_valid, out_ready;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [DW-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
    logic [DW-1:0] out_apb_re, out_apb_im, out_amb_re, out_amb_im;

    fft_butterfly_add_stage_multi #(
        .LANES(LANES), .TAG_W(TAG_W), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rot_mj(in_rot_mj), .in_scale(in_scale), .in_tag(in_tag),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_apb_re(out_apb_re), .out_apb_im(out_apb_im),
        .out_amb_re(out_amb_re), .out_amb_im(out_amb_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    apb_re, apb_im, amb_re, amb_im;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0, checks = 0;
    int n_acc = 0, n_pop = 0;
    bit occ_chk_en = 1'b0;
    logic [TAG_W-1:0] tag_ctr = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model (IEEE binary32 via real) ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        logic [22:0] m;
        int e, p;
        e = int'(x[30:23]);
        m = x[22:0];
        if (e == 0 && m == 0) begin
            d = {x[31], 63'd0};
        end else if (e == 0) begin
            p = 22;
            while (!m[p]) p--;
            d = {x[31], 11'(p - 149 + 1023), 52'(52'(m) << (52 - p))};
        end else begin
            d = {x[31], 11'(e - 127 + 1023), m, 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        longint unsigned s, q, rem, half;
        int e, sh;
        logic sg;
        d = $realtobits(r);
        sg = d[63];
        if (d[62:52] == 11'd0) return {sg, 31'd0};
        e = int'(d[62:52]) - 1023;
        s = {11'd0, 1'b1, d[51:0]};
        sh = (e >= -126) ? 29 : 29 + (-126 - e);
        if (sh > 60) return {sg, 31'd0};
        q = s >> sh;
        rem = s & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (e >= -126) begin
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e > 127) return {sg, 8'hFF, 23'd0};
            return {sg, 8'(e + 127), q[22:0]};
        end
        return {sg, q[23] ? 8'd1 : 8'd0, q[22:0]};
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 23'd0;
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 23'd0;
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
        real r;
        if (is_nan(x) || is_nan(y)) return 32'h7FC0_0000;
        if (is_inf(x) && is_inf(y)) return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        r = f2r(x) + f2r(y);
        if (r == 0.0) return {x[31] & y[31], 31'd0};
        return r2f(r);
    endfunction

    function automatic logic [31:0] m_scale(input logic [31:0] x, input logic sc);
`ifdef FFT_BF_SCALE_EN
        if (sc && x[30:23] != 8'hFF) begin
            if (x[30:23] <= 8'd1) return {x[31], 31'd0};
            return {x[31], x[30:23] - 8'd1, x[22:0]};
        end
`endif
        if (sc) return x;
        return x;
    endfunction

    function automatic exp_t model();
        exp_t r;
        logic [31:0] ar, ai, br, bi;
        r.tag = in_tag;
        for (int k = 0; k < int'(LANES); k++) begin
            ar = in_a_re[k*32 +: 32];
            ai = in_a_im[k*32 +: 32];
            br = in_rot_mj ? in_b_im[k*32 +: 32] : in_b_re[k*32 +: 32];
            bi = in_rot_mj ? (in_b_re[k*32 +: 32] ^ SGN) : in_b_im[k*32 +: 32];
            r.apb_re[k*32 +: 32] = m_scale(m_add(ar, br), in_scale);
            r.apb_im[k*32 +: 32] = m_scale(m_add(ai, bi), in_scale);
            r.amb_re[k*32 +: 32] = m_scale(m_add(ar, br ^ SGN), in_scale);
            r.amb_im[k*32 +: 32] = m_scale(m_add(ai, bi ^ SGN), in_scale);
        end
        return r;
    endfunction

    // ---------------- scoreboard processes ----------------
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back(model());
            n_acc++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_pop++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got tag %h expected no output", out_tag);
            end else begin
                e = sb_q.pop_front();
                if (out_tag !== e.tag || out_apb_re !== e.apb_re || out_apb_im !== e.apb_im ||
                    out_amb_re !== e.amb_re || out_amb_im !== e.amb_im) begin
                    errors++;
                    $display("FAIL output: got tag=%h apb=%h/%h amb=%h/%h expected tag=%h apb=%h/%h amb=%h/%h",
                             out_tag, out_apb_re, out_apb_im, out_amb_re, out_amb_im,
                             e.tag, e.apb_re, e.apb_im, e.amb_re, e.amb_im);
                end
            end
        end
    end

    // in_ready must reflect exactly whether accepted-but-not-delivered work fills the FIFO.
    always @(posedge clk) begin
        #2;
        if (rst_n && occ_chk_en) begin
            checks++;
            if (in_ready !== ((n_acc - n_pop) < int'(FIFO_DEPTH))) begin
                errors++;
                $display("FAIL in_ready_credit: got %b expected %b (outstanding %0d)",
                         in_ready, (n_acc - n_pop) < int'(FIFO_DEPTH), n_acc - n_pop);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_f();
        logic [31:0] sp [8];
        sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7FC0_0001, 32'h0000_0001, 32'h807F_FFFF, 32'h7F7F_FFFF};
        case ($urandom_range(0, 19))
            0: return sp[$urandom_range(0, 7)];
            1: return {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(112, 140)), 23'($urandom)};
        endcase
    endfunction

    task automatic rand_in();
        logic [31:0] ar, ai, br, bi;
        for (int k = 0; k < int'(LANES); k++) begin
            ar = rand_f(); ai = rand_f(); br = rand_f(); bi = rand_f();
            case ($urandom_range(0, 9))
                0: br = ar;
                1: bi = ai ^ SGN;
                2: br = ai;
                default: ;
            endcase
            in_a_re[k*32 +: 32] = ar; in_a_im[k*32 +: 32] = ai;
            in_b_re[k*32 +: 32] = br; in_b_im[k*32 +: 32] = bi;
        end
        in_rot_mj = 1'($urandom_range(0, 1));
        in_scale  = 1'($urandom_range(0, 1));
        in_tag    = tag_ctr;
        tag_ctr   = tag_ctr + 1'b1;
    endtask

    task automatic directed(input string name, input logic [31:0] ar, ai, br, bi,
                            input logic rot, sc, input logic [31:0] xr, xi, yr, yi);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a_re = {LANES{ar}}; in_a_im = {LANES{ai}};
        in_b_re = {LANES{br}}; in_b_im = {LANES{bi}};
        in_rot_mj = rot; in_scale = sc; in_tag = tag_ctr; in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(ADD_LAT + 1));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag_ctr));
        chk({name, "_apb_re"}, out_apb_re, {LANES{xr}});
        chk({name, "_apb_im"}, out_apb_im, {LANES{xi}});
        chk({name, "_amb_re"}, out_amb_re, {LANES{yr}});
        chk({name, "_amb_im"}, out_amb_im, {LANES{yi}});
        tag_ctr = tag_ctr + 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({name, "_out_data"}, out_apb_re | out_apb_im | out_amb_re | out_amb_im, 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_cnt, start, cyc, pop0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rot_mj = 1'b0; in_scale = 1'b0;
        in_tag = '0; in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        occ_chk_en = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");

        directed("basic", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b0, 1'b0,
                 32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4040_0000);
        directed("rot_mj", 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 1'b1, 1'b0,
                 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
`ifdef FFT_BF_SCALE_EN
        directed("scale", 32'h4080_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b1,
                 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
`else
        directed("scale", 32'h4080_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b1,
                 32'h40C0_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
`endif
        drain("directed");

        // Backpressure: ten offers against a stalled consumer.
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_cnt = 0;
        pop0 = n_pop;
        for (int i = 0; i < 10; i++) begin
            rand_in();
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(acc_cnt), 64'(FIFO_DEPTH));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        drain("bp");
        chk("bp_popped", 64'(n_pop - pop0), 64'(FIFO_DEPTH));

        // Random traffic with random consumer stalls.
        start = n_acc;
        cyc = 0;
        while (n_acc - start < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            rand_in();
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rand_count", 64'(n_acc - start >= 1000), 64'd1);
        drain("rand");

        // Reset with work both in the pipe and in the FIFO.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_in();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        n_acc = 0;
        n_pop = 0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midreset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset_quiet", 64'(out_valid), 64'd0);
        end
        directed("post_reset", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
                 1'b0, 1'b0, 32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4040_0000);
        drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
